// File: rtl/vscale_hasti_sram_slave_pkg.sv
// Shared HASTI bus widths, encodings and slave FSM states.
// Imported by every file of the SRAM slave so no encoding is repeated locally.
package vscale_hasti_sram_slave_pkg;

  localparam int HASTI_ADDR_WIDTH  = 32;
  localparam int HASTI_BUS_WIDTH   = 32;
  localparam int HASTI_BUS_NBYTES  = HASTI_BUS_WIDTH / 8;
  localparam int HASTI_SIZE_WIDTH  = 3;
  localparam int HASTI_TRANS_WIDTH = 2;
  localparam int HASTI_RESP_WIDTH  = 1;
  localparam int HASTI_WAIT_WIDTH  = 4;

  typedef enum logic [HASTI_TRANS_WIDTH-1:0] {
    HTRANS_IDLE   = 2'd0,
    HTRANS_BUSY   = 2'd1,
    HTRANS_NONSEQ = 2'd2,
    HTRANS_SEQ    = 2'd3
  } htrans_e;

  localparam logic [HASTI_SIZE_WIDTH-1:0] HSIZE_BYTE = 3'd0;
  localparam logic [HASTI_SIZE_WIDTH-1:0] HSIZE_HALF = 3'd1;
  localparam logic [HASTI_SIZE_WIDTH-1:0] HSIZE_WORD = 3'd2;

  localparam logic [HASTI_RESP_WIDTH-1:0] HRESP_OKAY  = 1'b0;
  localparam logic [HASTI_RESP_WIDTH-1:0] HRESP_ERROR = 1'b1;

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WAIT = 3'd1,
    S_DATA = 3'd2,
    S_ERR1 = 3'd3,
    S_ERR2 = 3'd4
  } state_e;

  // Little-endian lane enables for an aligned transfer of the given size.
  function automatic logic [HASTI_BUS_NBYTES-1:0] byte_mask(
    input logic [HASTI_SIZE_WIDTH-1:0] size,
    input logic [1:0]                  offset
  );
    case (size)
      HSIZE_BYTE: byte_mask = 4'b0001 << offset;
      HSIZE_HALF: byte_mask = 4'b0011 << offset;
      default:    byte_mask = 4'b1111;
    endcase
  endfunction

  function automatic logic is_aligned(
    input logic [HASTI_SIZE_WIDTH-1:0] size,
    input logic [1:0]                  offset
  );
    case (size)
      HSIZE_BYTE: is_aligned = 1'b1;
      HSIZE_HALF: is_aligned = (offset[0] == 1'b0);
      default:    is_aligned = (offset == 2'b00);
    endcase
  endfunction

endpackage

// File: rtl/vscale_bytemask_ram.sv
// NWORDS x 32 storage: one byte-enabled synchronous write port,
// one combinational read port.
module vscale_bytemask_ram
  import vscale_hasti_sram_slave_pkg::*;
#(
  parameter int NWORDS = 1024,
  parameter int AW     = 10
) (
  input  logic                        clk,
  input  logic                        we_i,
  input  logic [HASTI_BUS_NBYTES-1:0] be_i,
  input  logic [AW-1:0]               waddr_i,
  input  logic [HASTI_BUS_WIDTH-1:0]  wdata_i,
  input  logic [AW-1:0]               raddr_i,
  output logic [HASTI_BUS_WIDTH-1:0]  rdata_o
);

  logic [HASTI_BUS_WIDTH-1:0] mem [NWORDS];

  // NOTE: storage has no reset; contents must survive a bus reset.
  always_ff @(posedge clk) begin
    if (we_i) begin
      for (int i = 0; i < HASTI_BUS_NBYTES; i++) begin
        if (be_i[i]) mem[waddr_i][8*i +: 8] <= wdata_i[8*i +: 8];
      end
    end
  end

  assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/vscale_hasti_sram_slave.sv
// HASTI (AHB-Lite) SRAM slave: configurable wait states, two-cycle ERROR
// response for out-of-range, misaligned or oversize transfers.
module vscale_hasti_sram_slave
  import vscale_hasti_sram_slave_pkg::*;
#(
  parameter int NWORDS      = 1024,
  parameter int WAIT_STATES = 0
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         hsel,
  input  logic [HASTI_ADDR_WIDTH-1:0]  haddr,
  input  logic                         hwrite,
  input  logic [HASTI_SIZE_WIDTH-1:0]  hsize,
  input  logic [2:0]                   hburst,
  input  logic                         hmastlock,
  input  logic [3:0]                   hprot,
  input  logic [HASTI_TRANS_WIDTH-1:0] htrans,
  input  logic [HASTI_BUS_WIDTH-1:0]   hwdata,
  output logic [HASTI_BUS_WIDTH-1:0]   hrdata,
  output logic                         hready,
  output logic [HASTI_RESP_WIDTH-1:0]  hresp
);

  localparam int AW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [HASTI_WAIT_WIDTH-1:0] WAIT_INIT =
    HASTI_WAIT_WIDTH'((WAIT_STATES > 0) ? WAIT_STATES - 1 : 0);

  state_e                        state_q;
  logic [HASTI_WAIT_WIDTH-1:0]   cnt_q;
  logic [AW-1:0]                 word_q;
  logic [1:0]                    off_q;
  logic                          write_q;
  logic [HASTI_SIZE_WIDTH-1:0]   size_q;
  logic                          hready_q;
  logic [HASTI_RESP_WIDTH-1:0]   hresp_q;
  logic                          rd_valid_q;

  logic                          accept;
  logic                          legal;
  logic                          mem_we;
  logic [HASTI_BUS_WIDTH-1:0]    mem_rdata;
  logic                          unused_ignored;

  assign unused_ignored = ^{hburst, hmastlock, hprot};

  assign accept = hready_q && hsel &&
                  ((htrans == HTRANS_NONSEQ) || (htrans == HTRANS_SEQ));
  assign legal  = ({2'b00, haddr[HASTI_ADDR_WIDTH-1:2]} < 32'(NWORDS)) &&
                  (hsize <= HSIZE_WORD) && is_aligned(hsize, haddr[1:0]);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      word_q     <= '0;
      off_q      <= '0;
      write_q    <= 1'b0;
      size_q     <= '0;
      hready_q   <= 1'b1;
      hresp_q    <= HRESP_OKAY;
      rd_valid_q <= 1'b0;
    end else begin
      case (state_q)
        S_WAIT: begin
          if (cnt_q == '0) begin
            state_q    <= S_DATA;
            hready_q   <= 1'b1;
            rd_valid_q <= !write_q;
          end else begin
            cnt_q <= cnt_q - 1'b1;
          end
        end
        S_ERR1: begin
          state_q  <= S_ERR2;
          hready_q <= 1'b1;
        end
        default: begin
          // IDLE, DATA and ERR2 all complete with hready=1, so the address
          // phase on the bus is sampled here.
          hready_q   <= 1'b1;
          hresp_q    <= HRESP_OKAY;
          rd_valid_q <= 1'b0;
          if (accept) begin
            word_q  <= haddr[AW+1:2];
            off_q   <= haddr[1:0];
            write_q <= hwrite;
            size_q  <= hsize;
            if (!legal) begin
              state_q  <= S_ERR1;
              hready_q <= 1'b0;
              hresp_q  <= HRESP_ERROR;
            end else if (WAIT_STATES > 0) begin
              state_q  <= S_WAIT;
              cnt_q    <= WAIT_INIT;
              hready_q <= 1'b0;
            end else begin
              state_q    <= S_DATA;
              rd_valid_q <= !hwrite;
            end
          end else begin
            state_q <= S_IDLE;
          end
        end
      endcase
    end
  end

  // NOTE: reset at the data-phase edge must not let a pending write commit.
  assign mem_we = (state_q == S_DATA) && write_q && !reset;

  vscale_bytemask_ram #(
    .NWORDS (NWORDS),
    .AW     (AW)
  ) u_ram (
    .clk     (clk),
    .we_i    (mem_we),
    .be_i    (byte_mask(size_q, off_q)),
    .waddr_i (word_q),
    .wdata_i (hwdata),
    .raddr_i (word_q),
    .rdata_o (mem_rdata)
  );

  assign hready = hready_q;
  assign hresp  = hresp_q;
  assign hrdata = rd_valid_q ? mem_rdata : '0;

endmodule

// File: tb/tb_vscale_hasti_sram_slave.sv
// Directed bench: one zero-wait instance and one 3-wait instance share a
// single master; use_ws routes hsel and selects which response is observed.
module tb_vscale_hasti_sram_slave;
  import vscale_hasti_sram_slave_pkg::*;

  localparam int NW       = 256;
  localparam int MAX_WAIT = 40;

  logic        clk = 1'b0;
  logic        reset;
  logic        hsel;
  logic [31:0] haddr;
  logic        hwrite;
  logic [2:0]  hsize;
  logic [2:0]  hburst = 3'd0;
  logic        hmastlock = 1'b0;
  logic [3:0]  hprot = 4'd0;
  logic [1:0]  htrans;
  logic [31:0] hwdata;
  logic        use_ws;

  logic [31:0] hrdata0, hrdata1, hrdata;
  logic        hready0, hready1, hready;
  logic        hresp0, hresp1, hresp;
  logic        hsel0, hsel1;

  assign hsel0  = hsel && !use_ws;
  assign hsel1  = hsel && use_ws;
  assign hrdata = use_ws ? hrdata1 : hrdata0;
  assign hready = use_ws ? hready1 : hready0;
  assign hresp  = use_ws ? hresp1  : hresp0;

  vscale_hasti_sram_slave #(.NWORDS(NW), .WAIT_STATES(0)) dut0 (
    .clk(clk), .reset(reset), .hsel(hsel0), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hmastlock(hmastlock), .hprot(hprot),
    .htrans(htrans), .hwdata(hwdata), .hrdata(hrdata0), .hready(hready0),
    .hresp(hresp0)
  );

  vscale_hasti_sram_slave #(.NWORDS(NW), .WAIT_STATES(3)) dut1 (
    .clk(clk), .reset(reset), .hsel(hsel1), .haddr(haddr), .hwrite(hwrite),
    .hsize(hsize), .hburst(hburst), .hmastlock(hmastlock), .hprot(hprot),
    .htrans(htrans), .hwdata(hwdata), .hrdata(hrdata1), .hready(hready1),
    .hresp(hresp1)
  );

  always #5 clk = ~clk;

  int n_vec  = 0;
  int n_miss = 0;
  logic [31:0] model [NW];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_miss++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic addr_phase(input logic sel, input logic [1:0] trans, input logic wr,
                            input logic [31:0] addr, input logic [2:0] size);
    hsel   = sel;
    htrans = trans;
    hwrite = wr;
    haddr  = addr;
    hsize  = size;
  endtask

  task automatic idle_bus();
    addr_phase(1'b0, HTRANS_IDLE, 1'b0, 32'h0, HSIZE_WORD);
  endtask

  // One isolated transfer; returns completing-cycle data/resp, the response
  // seen in the first data-phase cycle, and the number of hready-low cycles.
  task automatic xfer(input logic wr, input logic [31:0] addr, input logic [2:0] size,
                      input logic [31:0] wdata, output logic [31:0] rdata,
                      output logic resp, output logic first_resp, output int waits);
    addr_phase(1'b1, HTRANS_NONSEQ, wr, addr, size);
    step();
    idle_bus();
    hwdata     = wdata;
    first_resp = hresp;
    waits      = 0;
    while (hready !== 1'b1 && waits < MAX_WAIT) begin
      waits++;
      step();
    end
    rdata = hrdata;
    resp  = hresp;
    step();
  endtask

  logic [31:0] rd;
  logic        rsp, frsp;
  int          wt;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
    $fatal(1);
  end

  initial begin
    reset  = 1'b1;
    use_ws = 1'b0;
    hwdata = '0;
    idle_bus();
    step();
    step();
    check("rst_hready", 32'(hready0), 32'd1);
    check("rst_hresp",  32'(hresp0),  32'd0);
    check("rst_hrdata", hrdata0,      32'h0);
    check("rst_hready_ws", 32'(hready1), 32'd1);
    reset = 1'b0;

    // Zero-wait pipelined write then read of the same word.
    addr_phase(1'b1, HTRANS_NONSEQ, 1'b1, 32'h10, HSIZE_WORD);
    step();
    check("w10_ready", 32'(hready), 32'd1);
    hwdata = 32'hDEADBEEF;
    addr_phase(1'b1, HTRANS_NONSEQ, 1'b0, 32'h10, HSIZE_WORD);
    step();
    check("r10_ready", 32'(hready), 32'd1);
    check("r10_resp",  32'(hresp),  32'd0);
    check("r10_data",  hrdata,      32'hDEADBEEF);
    idle_bus();
    hwdata = '0;
    step();
    check("idle_data", hrdata, 32'h0);

    // Byte and half-word lane writes.
    xfer(1'b1, 32'h10, HSIZE_WORD, 32'h11223344, rd, rsp, frsp, wt);
    check("w10_waits", 32'(wt), 32'd0);
    xfer(1'b1, 32'h13, HSIZE_BYTE, 32'hAA556677, rd, rsp, frsp, wt);
    check("wb13_resp", 32'(rsp), 32'd0);
    xfer(0, 32'h10, HSIZE_WORD, 32'h0, rd, rsp, frsp, wt);
    check("byte13_data", rd, 32'hAA223344);
    xfer(1'b1, 32'h11, HSIZE_BYTE, 32'h00009900, rd, rsp, frsp, wt);
    xfer(1'b0, 32'h10, HSIZE_WORD, 32'h0, rd, rsp, frsp, wt);
    check("byte11_data", rd, 32'hAA229944);
    xfer(1'b1, 32'h14, HSIZE_WORD, 32'hCAFEF00D, rd, rsp, frsp, wt);
    xfer(1'b1, 32'h16, HSIZE_HALF, 32'h12345678, rd, rsp, frsp, wt);
    xfer(1'b0, 32'h14, HSIZE_WORD, 32'h0, rd, rsp, frsp, wt);
    check("half16_data", rd, 32'h1234F00D);

    // Illegal transfers: two-cycle ERROR, memory untouched.
    xfer(1'b1, 32'h0, HSIZE_WORD, 32'h01020304, rd, rsp, frsp, wt);
    xfer(1'b0, 32'h400, HSIZE_WORD, 32'h0, rd, rsp, frsp, wt);
    check("oob_waits", 32'(wt),   32'd1);
    check("oob_err1",  32'(frsp), 32'd1);
    check("oob_err2",  32'(rsp),  32'd1);
    check("oob_data",  rd,        32'h0);
    xfer(1'b1, 32'h01, HSIZE_HALF, 32'hFFFFFFFF, rd, rsp, frsp, wt);
    check("mis_half_waits", 32'(wt),  32'd1);
    check("mis_half_err",   32'(rsp), 32'd1);
    xfer(1'b1, 32'h02, HSIZE_WORD, 32'hFFFFFFFF, rd, rsp, frsp, wt);
    check("mis_word_err", 32'(rsp), 32'd1);
    xfer(1'b0, 32'h0, 3'd3, 32'h0, rd, rsp, frsp, wt);
    check("big_size_err", 32'(rsp), 32'd1);
    xfer(1'b0, 32'h0, HSIZE_WORD, 32'h0, rd, rsp, frsp, wt);
    check("err_mem_kept", rd, 32'h01020304);

    // NONSEQ issued during ERR2 completes normally.
    addr_phase(1'b1, HTRANS_NONSEQ, 1'b0, 32'h400, HSIZE_WORD);
    step();
    check("e1_ready", 32'(hready), 32'd0);
    check("e1_resp",  32'(hresp),  32'd1);
    idle_bus();
    step();
    check("e2_ready", 32'(hready), 32'd1);
    check("e2_resp",  32'(hresp),  32'd1);
    addr_phase(1'b1, HTRANS_NONSEQ, 1'b0, 32'h10, HSIZE_WORD);
    step();
    check("after_err_ready", 32'(hready), 32'd1);
    check("after_err_resp",  32'(hresp),  32'd0);
    check("after_err_data",  hrdata,      32'hAA229944);
    idle_bus();
    step();

    // Three wait states.
    use_ws = 1'b1;
    step();
    xfer(1'b1, 32'h20, HSIZE_WORD, 32'h5A5A0001, rd, rsp, frsp, wt);
    check("ws_w_waits", 32'(wt), 32'd3);
    xfer(1'b0, 32'h20, HSIZE_WORD, 32'h0, rd, rsp, frsp, wt);
    check("ws_r_waits", 32'(wt),   32'd3);
    check("ws_r_wresp", 32'(frsp), 32'd0);
    check("ws_r_resp",  32'(rsp),  32'd0);
    check("ws_r_data",  rd,        32'h5A5A0001);

    // Reset during S_WAIT of a write abandons it.
    addr_phase(1'b1, HTRANS_NONSEQ, 1'b1, 32'h20, HSIZE_WORD);
    step();
    check("ws_rst_wait", 32'(hready), 32'd0);
    idle_bus();
    hwdata = 32'h77777777;
    step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    check("ws_rst_ready", 32'(hready), 32'd1);
    check("ws_rst_resp",  32'(hresp),  32'd0);
    xfer(1'b0, 32'h20, HSIZE_WORD, 32'h0, rd, rsp, frsp, wt);
    check("ws_rst_old", rd, 32'h5A5A0001);
    check("ws_rst_rwaits", 32'(wt), 32'd3);

    // Back-to-back traffic with BUSY and hsel=0 interleaved, checked against a model.
    use_ws = 1'b0;
    step();
    xfer(1'b1, 32'h48, HSIZE_WORD, 32'h48484848, rd, rsp, frsp, wt);
    model[32'h48 >> 2] = 32'h48484848;
    addr_phase(1'b1, HTRANS_NONSEQ, 1'b1, 32'h40, HSIZE_WORD);
    step();
    check("b2b_w40_ready", 32'(hready), 32'd1);
    hwdata = 32'h0BADF00D;
    model[32'h40 >> 2] = 32'h0BADF00D;
    addr_phase(1'b1, HTRANS_NONSEQ, 1'b0, 32'h40, HSIZE_WORD);
    step();
    check("b2b_r40_data", hrdata, model[32'h40 >> 2]);
    addr_phase(1'b1, HTRANS_BUSY, 1'b1, 32'h44, HSIZE_WORD);
    step();
    check("b2b_busy_ready", 32'(hready), 32'd1);
    check("b2b_busy_data",  hrdata,      32'h0);
    addr_phase(1'b1, HTRANS_NONSEQ, 1'b1, 32'h44, HSIZE_WORD);
    step();
    hwdata = 32'h13579BDF;
    model[32'h44 >> 2] = 32'h13579BDF;
    addr_phase(1'b0, HTRANS_NONSEQ, 1'b1, 32'h48, HSIZE_WORD);
    step();
    check("b2b_nosel_ready", 32'(hready), 32'd1);
    check("b2b_nosel_resp",  32'(hresp),  32'd0);
    addr_phase(1'b1, HTRANS_NONSEQ, 1'b0, 32'h44, HSIZE_WORD);
    step();
    check("b2b_r44_data", hrdata, model[32'h44 >> 2]);
    idle_bus();
    step();
    xfer(1'b0, 32'h48, HSIZE_WORD, 32'h0, rd, rsp, frsp, wt);
    check("b2b_r48_data", rd, model[32'h48 >> 2]);
    xfer(1'b0, 32'h40, HSIZE_WORD, 32'h0, rd, rsp, frsp, wt);
    check("b2b_r40_again", rd, model[32'h40 >> 2]);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
